// File: rtl/mmcm_phase_shifter_multi_pkg.sv
// Shared types and constants for the multi-channel MMCM phase stepper.
// MMCM_PS_TIMEOUT_EN enables the per-channel psdone timeout. The counter width helper below sizes that timeout counter.
package mmcm_ps_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } ps_state_e;

    localparam int unsigned DEFAULT_WIDTH          = 16;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1023;

    function automatic int unsigned timeout_cnt_w(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

    localparam int unsigned DEFAULT_TIMEOUT_CNT_W = timeout_cnt_w(DEFAULT_TIMEOUT_CYCLES);

endpackage

// File: rtl/mmcm_phase_shifter_multi_if.sv
// Bundle between the phase-shift controller (master: config bank plus MMCM psdone) and the stepper (slave).
interface mmcm_phase_shifter_multi_if #(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned WIDTH = 16
);
    logic [N_CH-1:0]       enable;
    logic [N_CH*WIDTH-1:0] target;
    logic [N_CH-1:0]       psdone;
    logic                  err_clr;
    logic [N_CH-1:0]       psen;
    logic [N_CH-1:0]       psincdec;
    logic [N_CH*WIDTH-1:0] phase;
    logic [N_CH-1:0]       busy;
    logic                  ready;
    logic [N_CH-1:0]       err;

    modport master (
        output enable, target, psdone, err_clr,
        input  psen, psincdec, phase, busy, ready, err
    );

    modport slave (
        input  enable, target, psdone, err_clr,
        output psen, psincdec, phase, busy, ready, err
    );
endinterface

// File: rtl/mmcm_phase_shifter_multi_channel.sv
// One MMCM phase-shift channel. It has a two-state FSM, a signed position counter and a sticky spurious-psdone flag.
// When MMCM_PS_TIMEOUT_EN is defined, the channel gives up waiting for psdone after TIMEOUT_CYCLES cycles.
module mmcm_ps_channel
    import mmcm_ps_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
`ifdef MMCM_PS_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable_i,
    input  logic signed [WIDTH-1:0] target_i,
    input  logic                    psdone_i,
    input  logic                    err_clr_i,
    output logic                    psen_o,
    output logic                    psincdec_o,
    output logic signed [WIDTH-1:0] phase_o,
    output logic                    busy_o,
    output logic                    err_o,
    output logic                    at_target_o
);

    localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1);

    ps_state_e               state_q, state_d;
    logic                    psen_q, psen_d;
    logic                    pid_q, pid_d;
    logic signed [WIDTH-1:0] phase_q, phase_d;
    logic                    err_q, err_d;
    logic                    timeout;

`ifdef MMCM_PS_TIMEOUT_EN
    localparam int unsigned CNT_W = timeout_cnt_w(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (state_q == WAIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        psen_d  = 1'b0;
        pid_d   = pid_q;
        phase_d = phase_q;
        // A new spurious psdone beats a simultaneous clear.
        err_d   = err_q & ~err_clr_i;
        unique case (state_q)
            IDLE: begin
                if (psdone_i) begin
                    err_d = 1'b1;
                end
                if (enable_i && (phase_q != target_i)) begin
                    psen_d  = 1'b1;
                    pid_d   = (target_i > phase_q);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (psdone_i) begin
                    phase_d = pid_q ? (phase_q + ONE) : (phase_q - ONE);
                    state_d = IDLE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            psen_q  <= 1'b0;
            pid_q   <= 1'b0;
            phase_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            psen_q  <= psen_d;
            pid_q   <= pid_d;
            phase_q <= phase_d;
            err_q   <= err_d;
        end
    end

    assign psen_o      = psen_q;
    assign psincdec_o  = pid_q;
    assign phase_o     = phase_q;
    assign busy_o      = (state_q == WAIT);
    assign err_o       = err_q;
    assign at_target_o = (state_q == IDLE) && (phase_q == target_i);

endmodule

// File: rtl/mmcm_phase_shifter_multi.sv
// N_CH independent MMCM dynamic phase steppers, each driving psen/psincdec toward its target.
// The MMCM_PS_TIMEOUT_EN macro enables the per-channel psdone timeout, and TIMEOUT_CYCLES sets its length.
module mmcm_phase_shifter_multi
    import mmcm_ps_pkg::*;
#(
    parameter int unsigned N_CH           = 2,
    parameter int unsigned WIDTH          = DEFAULT_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input logic                         clk,
    input logic                         rst,
    mmcm_phase_shifter_multi_if.slave   bus
);

    logic [N_CH-1:0] at_target;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        mmcm_ps_channel #(
            .WIDTH          (WIDTH)
`ifdef MMCM_PS_TIMEOUT_EN
            ,
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .enable_i    (bus.enable[i]),
            .target_i    (bus.target[i*WIDTH +: WIDTH]),
            .psdone_i    (bus.psdone[i]),
            .err_clr_i   (bus.err_clr),
            .psen_o      (bus.psen[i]),
            .psincdec_o  (bus.psincdec[i]),
            .phase_o     (bus.phase[i*WIDTH +: WIDTH]),
            .busy_o      (bus.busy[i]),
            .err_o       (bus.err[i]),
            .at_target_o (at_target[i])
        );
    end

    assign bus.ready = &at_target;

endmodule

// File: tb/tb_mmcm_phase_shifter_multi.sv
// Directed bench for mmcm_phase_shifter_multi with a 12-cycle psdone model that can be suppressed.
module tb_mmcm_phase_shifter_multi;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] inj;
    logic       auto_en;

    int checks = 0;
    int errors = 0;

    int pulses [2];
    int incs   [2];
    int decs   [2];
    int viol = 0;
    logic [1:0] prev_busy;
    logic [1:0] prev_pid;

    logic [1:0] dly [12];

    int base_p0;
    int base_i0;
    int base_d0;
    int base_p1;
    int base_d1;

    mmcm_phase_shifter_multi_if #(.N_CH(2), .WIDTH(16)) bus ();

    mmcm_phase_shifter_multi #(
        .N_CH           (2),
        .WIDTH          (16),
        .TIMEOUT_CYCLES (20)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // The MMCM model is reset along with the DUT.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 12; k++) dly[k] <= '0;
        end else begin
            dly[0] <= bus.psen;
            for (int k = 1; k < 12; k++) dly[k] <= dly[k-1];
        end
    end

    assign bus.psdone = (dly[11] & {2{auto_en}}) | inj;

    initial begin
        for (int i = 0; i < 2; i++) begin
            pulses[i] = 0;
            incs[i]   = 0;
            decs[i]   = 0;
        end
        prev_busy = '0;
        prev_pid  = '0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (bus.psen[i] === 1'b1) begin
                pulses[i] = pulses[i] + 1;
                if (bus.psincdec[i] === 1'b1) incs[i] = incs[i] + 1;
                else decs[i] = decs[i] + 1;
            end
            if (prev_busy[i] && bus.busy[i] && (bus.psincdec[i] !== prev_pid[i])) viol = viol + 1;
            prev_busy[i] = bus.busy[i];
            prev_pid[i]  = bus.psincdec[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.ready !== 1'b1 && n < budget);
        chk(tag, {31'd0, bus.ready}, 32'd1);
    endtask

    task automatic wait_busy0_at(input string tag, input logic [15:0] ph, input int budget);
        int n;
        n = 0;
        while (!(bus.busy[0] === 1'b1 && bus.phase[15:0] === ph) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, bus.busy[0]}, 32'd1);
    endtask

    initial begin
        rst         = 1'b1;
        inj         = '0;
        auto_en     = 1'b1;
        bus.enable  = '0;
        bus.target  = '0;
        bus.err_clr = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_psen",  {30'd0, bus.psen}, 32'd0);
        chk("rst_phase", bus.phase, 32'd0);
        chk("rst_busy",  {30'd0, bus.busy}, 32'd0);
        chk("rst_err",   {30'd0, bus.err}, 32'd0);
        chk("rst_ready", {31'd0, bus.ready}, 32'd1);

        // ch0 steps 0 -> 3
        rst        = 1'b0;
        bus.enable = 2'b11;
        bus.target = {16'd0, 16'd3};
        wait_ready("t1_ready", 200);
        chk("t1_ph0",   {16'd0, bus.phase[15:0]},  32'd3);
        chk("t1_ph1",   {16'd0, bus.phase[31:16]}, 32'd0);
        chk("t1_puls0", pulses[0], 32'd3);
        chk("t1_inc0",  incs[0],   32'd3);
        chk("t1_puls1", pulses[1], 32'd0);

        // concurrent ch0 -> 5, ch1 -> -2
        bus.target = {16'hFFFE, 16'd5};
        wait_ready("t2_ready", 200);
        chk("t2_ph0",   {16'd0, bus.phase[15:0]},  32'd5);
        chk("t2_ph1",   {16'd0, bus.phase[31:16]}, 32'h0000_FFFE);
        chk("t2_puls0", pulses[0], 32'd5);
        chk("t2_inc0",  incs[0],   32'd5);
        chk("t2_puls1", pulses[1], 32'd2);
        chk("t2_dec1",  decs[1],   32'd2);

        // target retargeted from +10 to +1 while stepping from phase 4
        bus.target = {16'hFFFE, 16'd4};
        wait_ready("t3a_ready", 100);
        base_p0 = pulses[0];
        base_i0 = incs[0];
        base_d0 = decs[0];
        bus.target = {16'hFFFE, 16'd10};
        wait_busy0_at("t3_busy", 16'd4, 10);
        bus.target = {16'hFFFE, 16'd1};
        wait_ready("t3_ready", 300);
        chk("t3_ph0",   {16'd0, bus.phase[15:0]}, 32'd1);
        chk("t3_puls0", pulses[0] - base_p0, 32'd5);
        chk("t3_inc0",  incs[0] - base_i0,   32'd1);
        chk("t3_dec0",  decs[0] - base_d0,   32'd4);
        chk("t3_pidstable", viol, 32'd0);

        // spurious psdone in IDLE, clear, and set-beats-clear
        repeat (2) @(negedge clk);
        inj = 2'b01;
        @(negedge clk);
        inj = 2'b00;
        chk("t4_ph0", {16'd0, bus.phase[15:0]}, 32'd1);
        chk("t4_err", {30'd0, bus.err}, 32'd1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("t4_clr", {30'd0, bus.err}, 32'd0);
        inj = 2'b01;
        bus.err_clr = 1'b1;
        @(negedge clk);
        inj = 2'b00;
        bus.err_clr = 1'b0;
        chk("t4_setwins", {30'd0, bus.err}, 32'd1);

        // asynchronous reset while waiting at phase 7
        bus.target = {16'hFFFE, 16'd7};
        wait_ready("t5a_ready", 300);
        bus.target = {16'hFFFE, 16'd8};
        wait_busy0_at("t5_busy", 16'd7, 10);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_psen",  {30'd0, bus.psen}, 32'd0);
        chk("t5_phase", bus.phase, 32'd0);
        chk("t5_busy",  {30'd0, bus.busy}, 32'd0);
        chk("t5_err",   {30'd0, bus.err}, 32'd0);
        chk("t5_ready", {31'd0, bus.ready}, 32'd0);
        @(negedge clk);

        // psdone suppressed
        auto_en    = 1'b0;
        bus.target = {16'd0, 16'd1};
        base_p1    = pulses[1];
        base_d1    = decs[1];
        rst        = 1'b0;
        base_p0    = pulses[0];
        wait_busy0_at("t6_busy", 16'd0, 10);
`ifdef MMCM_PS_TIMEOUT_EN
        repeat (19) @(negedge clk);
        chk("t6_busy19", {31'd0, bus.busy[0]}, 32'd1);
        chk("t6_err19",  {30'd0, bus.err}, 32'd0);
        @(negedge clk);
        chk("t6_busy20", {31'd0, bus.busy[0]}, 32'd0);
        chk("t6_err20",  {30'd0, bus.err}, 32'd1);
        chk("t6_ph0",    {16'd0, bus.phase[15:0]}, 32'd0);
        @(negedge clk);
        chk("t6_retry",  {31'd0, bus.psen[0]}, 32'd1);
        chk("t6_puls0",  pulses[0] - base_p0, 32'd2);
`else
        repeat (1000) @(negedge clk);
        chk("t6_busy", {31'd0, bus.busy[0]}, 32'd1);
        chk("t6_err",  {30'd0, bus.err}, 32'd0);
        chk("t6_ph0",  {16'd0, bus.phase[15:0]}, 32'd0);
        chk("t6_puls0", pulses[0] - base_p0, 32'd1);
`endif
        chk("t6_puls1", pulses[1] - base_p1, 32'd0);
        chk("t6_dec1",  decs[1] - base_d1,   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
